stream_demux: RTL and testbench

- Registered one-hot stream demultiplexer: routes each accepted input beat to exactly one of N valid/ready output lanes.
- Output lanes are concatenated the same way as the one-hot mux inputs, so this block is the distribution-side counterpart of that mux.
- One pipeline stage; full throughput when the destination lane is ready.
- Beats with an illegal select are dropped and flagged.

---
 rtl/stream_demux.sv | 86 ++++++++
 tb/tb_stream_demux.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered one-hot demultiplexer routing each input beat to one of N valid/ready lanes.
// Latency: 1 cycle from input acceptance to o_valid; zero-hot or multi-hot selects are dropped with an o_err pulse.
// Backpressure: i_ready = !full || the held beat drains this cycle, giving full throughput while the destination lane is ready.
// Optional: define STREAM_DEMUX_DROP_CNT_EN to add the 16-bit saturating o_drop_cnt output.
module stream_demux #(
  parameter int DW = 1,
  parameter int N  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [N-1:0]    i_sel,
  input  logic [DW-1:0]   i_data,
  output logic [N-1:0]    o_valid,
  input  logic [N-1:0]    o_ready,
  output logic [N*DW-1:0] o_data,
  output logic            o_err
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]     o_drop_cnt
`endif
);

  // Holding register: one beat plus its destination lane.
  typedef struct packed {
    logic          full;
    logic [N-1:0]  sel;
    logic [DW-1:0] data;
  } hold_t;

  hold_t hold_q;
  logic  err_q;
  logic  drain;
  logic  accept;
  logic  sel_legal;

  // A select is usable only when it names exactly one lane.
  assign sel_legal = ($countones(i_sel) == 1);

  // The held beat leaves when its own lane is ready; other lanes' ready is ignored.
  assign drain   = hold_q.full && (|(hold_q.sel & o_ready));
  assign i_ready = !rst && (!hold_q.full || drain);
  assign accept  = i_valid && i_ready;

  assign o_valid = hold_q.full ? hold_q.sel : '0;
  assign o_err   = err_q;

  // Lane data is gated so that only the active lane ever carries a non-zero value.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign o_data[k*DW +: DW] = o_valid[k] ? hold_q.data : '0;
  end

  // Holding register update: reload on legal accept (even while draining), clear on drain alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !sel_legal;
      if (accept && sel_legal) begin
        hold_q.full <= 1'b1;
        hold_q.sel  <= i_sel;
        hold_q.data <= i_data;
      end else if (drain) begin
        hold_q.full <= 1'b0;
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped illegal-select beats, stepping on the same edge as o_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (accept && !sel_legal && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of stream_demux with N=4, DW=8.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
// Each check compares {i_ready, o_err, o_valid, o_data} against a hand-computed vector.
module tb_stream_demux;

  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic            i_ready;
  logic [N-1:0]    i_sel;
  logic [DW-1:0]   i_data;
  logic [N-1:0]    o_valid;
  logic [N-1:0]    o_ready;
  logic [N*DW-1:0] o_data;
  logic            o_err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0]     o_drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [37:0] obs;
  logic [37:0] exp_v;

  stream_demux #(.DW(DW), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_sel   (i_sel),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_err   (o_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {i_ready, o_err, o_valid, o_data};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b1; i_sel = 4'b0001; i_data = 8'hFF; o_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      exp_v = {1'b0, 1'b0, 4'b0000, 32'h0};
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL reset[%0d]: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h", c,
                 obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
      end
      n_cmp++;
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    if (o_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_drop_cnt: got %0d want 0", o_drop_cnt);
    end
    n_cmp++;
`endif
    tick();
    rst = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_stream;
    logic [31:0] ed;
    o_ready = 4'b1111;
    for (int k = 0; k <= 4; k++) begin
      tick();
      i_valid = (k < 4);
      i_sel   = 4'b0001 << (k % 4);
      i_data  = 8'hA0 + 8'(k);
      #1;
      ed = 32'h0;
      if (k > 0) ed[(k-1)*8 +: 8] = 8'hA0 + 8'(k - 1);
      exp_v = {1'b1, 1'b0, (k > 0) ? (4'b0001 << (k - 1)) : 4'b0000, ed};
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL stream[%0d]: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h", k,
                 obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
      end
      n_cmp++;
    end
    tick();
    #1;
    exp_v = {1'b1, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stream_empty: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
  endtask

  task automatic test_stall;
    tick();
    i_valid = 1'b1; i_sel = 4'b0100; i_data = 8'h5C; o_ready = 4'b1011;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stall_load: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    for (int c = 0; c < 3; c++) begin
      tick();
      i_valid = 1'b1; i_sel = 4'b0001; i_data = 8'h11; o_ready = 4'b1011;
      #1;
      exp_v = {1'b0, 1'b0, 4'b0100, 32'h005C_0000};
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h", c,
                 obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
      end
      n_cmp++;
    end
    tick();
    o_ready = 4'b1111;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0100, 32'h005C_0000};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stall_drain: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    i_valid = 1'b0;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0001, 32'h0000_0011};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL stall_next: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_illegal;
    logic [3:0] sels [2];
    sels[0] = 4'b0000;
    sels[1] = 4'b0110;
    o_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      i_valid = (k < 2);
      i_sel   = sels[k % 2];
      i_data  = 8'h33 + 8'(k);
      #1;
      exp_v = {1'b1, (k == 1 || k == 2), 4'b0000, 32'h0};
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL illegal[%0d]: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h", k,
                 obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
      end
      n_cmp++;
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    if (o_drop_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL illegal_drop_cnt: got %0d want 2", o_drop_cnt);
    end
    n_cmp++;
`endif
  endtask

  task automatic test_back_to_back;
    tick();
    i_valid = 1'b1; i_sel = 4'b0010; i_data = 8'h66; o_ready = 4'b0000;
    #1;
    tick();
    i_valid = 1'b1; i_sel = 4'b1000; i_data = 8'h77; o_ready = 4'b0000;
    #1;
    exp_v = {1'b0, 1'b0, 4'b0010, 32'h0000_6600};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_held: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    o_ready = 4'b0010;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0010, 32'h0000_6600};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_swap: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    i_valid = 1'b0; o_ready = 4'b0000;
    #1;
    exp_v = {1'b0, 1'b0, 4'b1000, 32'h7700_0000};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_new: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    o_ready = 4'b1111;
    tick();
    #1;
    exp_v = {1'b1, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_empty: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    tick();
    i_valid = 1'b1; i_sel = 4'b0100; i_data = 8'h99; o_ready = 4'b0000;
    tick();
    i_valid = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 4'b0100, 32'h0099_0000};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_held: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_cleared: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    if (o_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_drop_cnt: got %0d want 0", o_drop_cnt);
    end
    n_cmp++;
`endif
    tick();
    i_valid = 1'b1; i_sel = 4'b0001; i_data = 8'h5A; o_ready = 4'b1111;
    tick();
    i_valid = 1'b0;
    #1;
    exp_v = {1'b1, 1'b0, 4'b0001, 32'h0000_005A};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_new: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
    tick();
    #1;
    exp_v = {1'b1, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_no_old: rdy/err/vld/data got %b/%b/%b/%h want %b/%b/%b/%h",
               obs[37], obs[36], obs[35:32], obs[31:0], exp_v[37], exp_v[36], exp_v[35:32], exp_v[31:0]);
    end
    n_cmp++;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sel = '0; i_data = '0; o_ready = '0;
    test_reset();
    test_stream();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
